// File: rtl/regfile_seq_if.sv
// Register-file sequencer bus: decode request, regfile read/write ports,
// operand hand-off to the ALU and completion/abort pulses.
// master = sequencer side, slave = environment (decode, regfile, ALU, din).
interface regfile_seq_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_rs1;
    logic [3:0]      req_rs2;
    logic [3:0]      req_rd;
    logic [1:0]      req_src;
    logic [1:0]      req_width;
    logic            req_we;
    logic [3:0]      rdasel;
    logic [3:0]      rdbsel;
    logic [XLEN-1:0] rdaout;
    logic [XLEN-1:0] rdbout;
    logic [3:0]      wrsel;
    logic            wr;
    logic [1:0]      width;
    logic            aluload;
    logic            immload;
    logic            retload;
    logic            setr;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            op_valid;
    logic            alu_valid;
    logic            din_valid;
    logic            done;
    logic            err;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_rd, req_src, req_width, req_we,
        input  rdaout, rdbout, alu_valid, din_valid,
        output req_ready, rdasel, rdbsel, wrsel, wr, width,
        output aluload, immload, retload, setr, opa, opb, op_valid, done, err
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_rd, req_src, req_width, req_we,
        output rdaout, rdbout, alu_valid, din_valid,
        input  req_ready, rdasel, rdbsel, wrsel, wr, width,
        input  aluload, immload, retload, setr, opa, opb, op_valid, done, err
    );
endinterface

// File: rtl/regfile_seq.sv
// Register-file access sequencer: accepts one request, reads both operands,
// waits on the selected result source and issues one write-back pulse.
// Optional macro REGFILE_SEQ_R0_ZERO_EN: register 0 reads as zero and is
// never written (done still pulses).
module regfile_seq #(
    parameter int TIMEOUT = 16,   // EXEC wait limit, 2..255
    parameter int XLEN    = 64
) (
    input  logic           clk,
    input  logic           reset,   // async, active low
    regfile_seq_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_RET = 2'd2;
    localparam logic [1:0] SRC_DIN = 2'd3;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [1:0] src;
        logic [1:0] width;
        logic       we;
    } req_t;

    state_t          state, nxt;
    req_t            rq;
    logic [7:0]      cnt;
    logic            rdy_q;
    logic            ready, accept, hit, wb_en, exec_src;
    logic            done_d, err_d, done_q, err_q;
    logic [3:0]      wrsel_q;
    logic [1:0]      width_q;
    logic [XLEN-1:0] opa_q, opb_q, opa_d, opb_d;

    // rdy_q keeps req_ready low until the first clock edge after reset release
    assign ready    = rdy_q && (state == S_IDLE);
    assign accept   = bus.req_valid && ready;
    assign hit      = (rq.src == SRC_DIN) ? bus.din_valid : bus.alu_valid;
    assign exec_src = (rq.src == SRC_ALU) || (rq.src == SRC_DIN);

`ifdef REGFILE_SEQ_R0_ZERO_EN
    assign opa_d = (rq.rs1 == 4'd0) ? '0 : bus.rdaout;
    assign opb_d = (rq.rs2 == 4'd0) ? '0 : bus.rdbout;
    assign wb_en = (state == S_WB) && (rq.rd != 4'd0);
`else
    assign opa_d = bus.rdaout;
    assign opb_d = bus.rdbout;
    assign wb_en = (state == S_WB);
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    // next state plus completion/abort pulse requests
    always_comb begin
        nxt    = state;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state)
            S_IDLE: if (accept) nxt = S_READ;
            S_READ: begin
                if (exec_src)   nxt = S_EXEC;
                else if (rq.we) nxt = S_WB;
                else begin
                    nxt    = S_IDLE;
                    done_d = 1'b1;
                end
            end
            S_EXEC: begin
                // a valid arriving on the last allowed cycle still counts
                if (hit) begin
                    if (rq.we) nxt = S_WB;
                    else begin
                        nxt    = S_IDLE;
                        done_d = 1'b1;
                    end
                end else if (cnt == CNT_LAST) begin
                    nxt   = S_IDLE;
                    err_d = 1'b1;
                end
            end
            S_WB: begin
                nxt    = S_IDLE;
                done_d = 1'b1;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // request latch, ready gate, EXEC cycle counter and output pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rq     <= '0;
            rdy_q  <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rdy_q  <= 1'b1;
            done_q <= done_d;
            err_q  <= err_d;
            cnt    <= (state == S_EXEC) ? cnt + 8'd1 : 8'd0;
            if (accept)
                rq <= '{rs1: bus.req_rs1, rs2: bus.req_rs2, rd: bus.req_rd,
                        src: bus.req_src, width: bus.req_width, we: bus.req_we};
        end
    end

    // operands captured at the end of READ, held until the next READ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state == S_READ) begin
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    // write select/width load on WB entry and hold afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrsel_q <= '0;
            width_q <= '0;
        end else if (nxt == S_WB && state != S_WB) begin
            wrsel_q <= rq.rd;
            width_q <= rq.width;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rdasel    = rq.rs1;
    assign bus.rdbsel    = rq.rs2;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.op_valid  = (state == S_EXEC);
    assign bus.wr        = wb_en;
    assign bus.wrsel     = wrsel_q;
    assign bus.width     = width_q;
    assign bus.aluload   = wb_en && (rq.src == SRC_ALU);
    assign bus.immload   = wb_en && (rq.src == SRC_IMM);
    assign bus.retload   = wb_en && (rq.src == SRC_RET);
    assign bus.setr      = wb_en && (rq.src == SRC_DIN);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Sequencer that sits on the other side of the register file interface and drives it.
- Accepts one register-access request at a time from decode and drives read selects.
- Registers both operands and hands them to the ALU.
- Waits for the selected result source, then issues a single write-back pulse with the matching load strobe and width.
- Replaces the ad-hoc select/strobe driving done today by the testbench and top-level glue.

Parameters:
- TIMEOUT, 16: max cycles waiting in EXEC for alu_valid/din_valid before abort; legal range 2..255.
- XLEN, 64: data width of operands.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_rs1  input  4  read port A register.
- req_rs2  input  4  read port B register.
- req_rd  input  4  destination register.
- req_src  input  2  write source: 0=ALU, 1=IMM, 2=RET, 3=DIN.
- req_width  input  2  write width code, passed to width.
- req_we  input  1  request performs write-back.
- rdasel  output  4  register file read A select.
- rdbsel  output  4  register file read B select.
- rdaout  input  XLEN  register file read A data.
- rdbout  input  XLEN  register file read B data.
- wrsel  output  4  register file write select.
- wr  output  1  register file write strobe.
- width  output  2  register file write width.
- aluload  output  1  write source ALU.
- immload  output  1  write source immediate.
- retload  output  1  write source return address.
- setr  output  1  write source din.
- opa  output  XLEN  registered operand A.
- opb  output  XLEN  registered operand B.
- op_valid  output  1  operands valid to ALU.
- alu_valid  input  1  aluout valid this cycle.
- din_valid  input  1  din valid this cycle.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle timeout pulse.

Behaviour:
- Reset (reset=0, async): all outputs 0 except req_ready=0 until first clk edge after release. State=IDLE, timeout counter=0, latched request fields=0.
- States: IDLE, READ, EXEC, WB.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch rs1, rs2, rd, src, width, we; go to READ.
- READ (1 cycle):
  - rdasel=rs1, rdbsel=rs2; regfile read is combinational.
  - opa/opb capture rdaout/rdbout at the end of the cycle.
  - Next state: src ALU or DIN -> EXEC; IMM or RET with we=1 -> WB; IMM or RET with we=0 -> IDLE with done pulse.
- EXEC:
  - op_valid=1; counter increments each cycle.
  - On the awaited valid (alu_valid for ALU, din_valid for DIN): go to WB if we=1, else go to IDLE with done pulse.
  - Non-matching valid is ignored.
  - Counter reaching TIMEOUT with no valid: err=1 for 1 cycle, no write, go to IDLE. If valid and timeout coincide, valid wins.
- WB (1 cycle):
  - wr=1, wrsel=rd, width=latched width, exactly one of aluload/immload/retload/setr=1 per src.
  - done=1 in the following cycle (IDLE).
- Outside WB: wr and all load strobes 0; wrsel/width hold last value.
- req_ready=0 in READ/EXEC/WB; no request queuing.
- op_valid is 1 only in EXEC.
- opa/opb hold until the next READ.
- Latency, accept edge to wr: IMM/RET 2 cycles; ALU/DIN 3 + wait cycles.
- Reset asserted mid-operation: immediate return to IDLE, no wr, no done.

Optional Feature:
- Macro: REGFILE_SEQ_R0_ZERO_EN.
- Defined: register 0 is hardwired zero.
  - Operand read from rs1=0/rs2=0 captures 0 regardless of rdaout/rdbout.
  - WB with rd=0 keeps wr and load strobes low; done still pulses.
- Undefined: register 0 is ordinary.

Test Plan:
- Reset during EXEC (ALU, no alu_valid) -> all outputs 0 immediately; after release req_ready=1 next cycle; no wr ever seen.
- ALU op: rs1=3, rs2=4, rd=5, width=3, rdaout=0x11, rdbout=0x22, alu_valid 3 cycles after op_valid -> opa=0x11, opb=0x22; wr=1, aluload=1, wrsel=5, width=3 for 1 cycle; done next cycle.
- IMM op: rd=7, we=1 -> wr=1, immload=1, wrsel=7 two cycles after accept; RET with we=0 -> no wr, done one cycle after READ.
- Timeout: TIMEOUT=8, DIN src, din_valid held 0 (alu_valid toggling) -> err pulse after 8 EXEC cycles, no wr, req_ready=1 next cycle.
- Back-to-back: req_valid held high with two requests -> second accepted only after first done; req_ready=0 throughout READ/EXEC/WB.
- With REGFILE_SEQ_R0_ZERO_EN: rs1=0, rdaout=0xFFFF -> opa=0; rd=0, src=IMM, we=1 -> wr stays 0, done pulses.
